// File: rtl/fifo_pkg.sv
// Shared definitions for the width-changing FIFO family: packer state
// encoding and default geometry used by fifo_upsize and its sub-blocks.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;

   typedef enum logic {
      HALF_EMPTY = 1'b0,
      HALF_FULL  = 1'b1
   } packer_state_t;

endpackage

// File: rtl/byte_packer.sv
// Collects pairs of bytes into one word: the first byte is staged, the second
// byte is joined with it and emitted as a commit strobe plus packed word.
// Optional FIFO_UPSIZE_FLUSH_EN adds a flush input that commits a lone staged
// byte padded with zeros in the low half.
module byte_packer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_wr,
   input  logic                    i_room,
   input  logic [DATA_WIDTH-1:0]   i_data,
`ifdef FIFO_UPSIZE_FLUSH_EN
   input  logic                    i_flush,
`endif
   output logic                    o_commit,
   output logic [2*DATA_WIDTH-1:0] o_word,
   output logic                    o_half
);

   packer_state_t         r_state;
   packer_state_t         w_next;
   logic [DATA_WIDTH-1:0] r_staged;
   logic                  w_acc;
   logic                  w_capture;

   // A byte is taken only when the storage can absorb a word this cycle
   // (room, or a read freeing a slot); otherwise it is silently dropped.
   assign w_acc = i_wr & i_room;

   // Next-state and commit decode; the first byte goes to the upper half.
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      o_commit  = 1'b0;
      o_word    = {r_staged, i_data};
      case (r_state)
         HALF_EMPTY: begin
            if (w_acc) begin
               w_capture = 1'b1;
               w_next    = HALF_FULL;
            end
         end
         HALF_FULL: begin
            if (w_acc) begin
               o_commit = 1'b1;
               w_next   = HALF_EMPTY;
            end
`ifdef FIFO_UPSIZE_FLUSH_EN
            else if (i_flush && !i_wr && i_room) begin
               o_commit = 1'b1;
               o_word   = {r_staged, {DATA_WIDTH{1'b0}}};
               w_next   = HALF_EMPTY;
            end
`endif
         end
         default: begin
            w_next = HALF_EMPTY;
         end
      endcase
   end

   // Packer state register; reset discards any pending byte.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= HALF_EMPTY;
      end else begin
         r_state <= w_next;
      end
   end

   // Staging register holds the first byte of a pair until its partner arrives.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_staged <= '0;
      end else if (w_capture) begin
         r_staged <= i_data;
      end
   end

   assign o_half = (r_state == HALF_FULL);

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and occupancy control for the word storage. A word count one bit
// wider than the pointers separates full from empty when pointers coincide.
module fifo_ctrl #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr,
   input  logic                  i_rd,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_w_addr,
   output logic [ADDR_WIDTH-1:0] o_r_addr,
   output logic                  o_empty,
   output logic                  o_full
);

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] r_w_ptr;
   logic [ADDR_WIDTH-1:0] r_r_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_empty;
   logic                  w_full;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_COUNT);
   assign w_pop   = i_rd & ~w_empty;
   // When full, a write is only allowed to land in the slot freed by a pop.
   assign w_push  = i_wr & (~w_full | w_pop);

   // Advance pointers and track occupancy; a simultaneous push and pop
   // leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_w_ptr <= '0;
         r_r_ptr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_w_ptr <= r_w_ptr + 1'b1;
         end
         if (w_pop) begin
            r_r_ptr <= r_r_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_wr_en  = w_push;
   assign o_w_addr = r_w_ptr;
   assign o_r_addr = r_r_ptr;
   assign o_empty  = w_empty;
   assign o_full   = w_full;

endmodule

// File: rtl/reg_file.sv
// Word storage for the FIFO: synchronous write port, asynchronous read port
// so the head word is visible in the same cycle the read pointer moves.
module reg_file #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_w_addr,
   input  logic [ADDR_WIDTH-1:0] i_r_addr,
   input  logic [DATA_WIDTH-1:0] i_w_data,
   output logic [DATA_WIDTH-1:0] o_r_data
);

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

   // Storage contents are never reset; only the slot at the tail is written.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_w_addr] <= i_w_data;
      end
   end

   assign o_r_data = r_mem[i_r_addr];

endmodule

// File: rtl/fifo_upsize.sv
// Width-upsizing first-word-fall-through FIFO: bytes in, packed double-width
// words out. A lone pending byte stays invisible to the reader until paired.
// Optional feature macro: FIFO_UPSIZE_FLUSH_EN (adds the flush input).
module fifo_upsize
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic                    rd,
`ifdef FIFO_UPSIZE_FLUSH_EN
   input  logic                    flush,
`endif
   output logic [2*DATA_WIDTH-1:0] r_data,
   output logic                    empty,
   output logic                    full,
   output logic                    half
);

   logic                    w_room;
   logic                    w_commit;
   logic [2*DATA_WIDTH-1:0] w_word;
   logic                    w_wr_en;
   logic [ADDR_WIDTH-1:0]   w_w_addr;
   logic [ADDR_WIDTH-1:0]   w_r_addr;
   logic                    w_empty;
   logic                    w_full;

   // Storage can take a word when not full, or when a read frees the head.
   assign w_room = ~w_full | rd;

   byte_packer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_packer (
      .clk      (clk),
      .reset    (reset),
      .i_wr     (wr),
      .i_room   (w_room),
      .i_data   (w_data),
`ifdef FIFO_UPSIZE_FLUSH_EN
      .i_flush  (flush),
`endif
      .o_commit (w_commit),
      .o_word   (w_word),
      .o_half   (half)
   );

   fifo_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ctrl (
      .clk      (clk),
      .reset    (reset),
      .i_wr     (w_commit),
      .i_rd     (rd),
      .o_wr_en  (w_wr_en),
      .o_w_addr (w_w_addr),
      .o_r_addr (w_r_addr),
      .o_empty  (w_empty),
      .o_full   (w_full)
   );

   reg_file #(
      .DATA_WIDTH (2*DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_regs (
      .clk      (clk),
      .i_wr_en  (w_wr_en),
      .i_w_addr (w_w_addr),
      .i_r_addr (w_r_addr),
      .i_w_data (w_word),
      .o_r_data (r_data)
   );

   assign empty = w_empty;
   assign full  = w_full;

endmodule
